// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous
// double-buffered data. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg_scan_ctrl #(
  parameter int unsigned DIV_CNT = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        LD,
  input  logic [15:0] DATA,
  output logic        PEND,
  output logic [3:0]  an,
  output logic [3:0]  DIGIT,
  output logic        FRAME
);

  localparam int unsigned CNT_W   = $clog2(DIV_CNT);
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned DATA_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_CNT - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic [DATA_W-1:0] pending_q, pending_d;
  logic              pend_q, pend_d;
  logic              frame_q, frame_d;
  logic              tick, wrap, xfer;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      frame_q   <= frame_d;
    end
  end

  // Prescaler, digit index, and pending->active handoff at frame boundaries
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    tick      = 1'b0;
    wrap      = 1'b0;
    xfer      = 1'b0;

    if (EN) begin
      tick = (cnt_q == CNT_MAX);
      if (tick) begin
        cnt_d = '0;
        idx_d = idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
      idx_d = '0;
    end

    wrap = tick && (idx_q == IDX_W'(3));
    xfer = wrap || (!EN && pend_q);

    if (xfer) begin
      active_d = pending_q;
      pend_d   = 1'b0;
    end
    // A load on the transfer edge wins the pending slot; active still gets the old value
    if (LD) begin
      pending_d = DATA;
      pend_d    = 1'b1;
    end

    frame_d = wrap;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd_pos;

  // Highest digit position holding a nonzero nibble; digit 0 always counts
  always_comb begin
    msd_pos = '0;
    if (active_q[15:12] != 4'h0)     msd_pos = IDX_W'(3);
    else if (active_q[11:8] != 4'h0) msd_pos = IDX_W'(2);
    else if (active_q[7:4] != 4'h0)  msd_pos = IDX_W'(1);
  end
`endif

  // Display decode depends only on registered state and EN
  always_comb begin
    an    = 4'b1111;
    DIGIT = 4'h0;
    if (EN) begin
      an[idx_q] = 1'b0;
      DIGIT     = active_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_q > msd_pos) an = 4'b1111;
`endif
    end
  end

  assign PEND  = pend_q;
  assign FRAME = frame_q && EN;

endmodule
